// File: rtl/idft_frame_seq.sv
// rtl/idft_frame_seq.sv - frame sequencer driving the streaming IDFT core
//
// Purpose: on start_i, feeds N samples from the input buffer into the IDFT
// core, waits for the core's output-frame marker, writes N results into the
// output buffer, then pulses done_o and sets the sticky int_o. A timeout or an
// early core marker ends the frame in ERR and sets err_o/int_o instead.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   start_i, clr_i               frame start request, sticky status clear
//   busy_o, done_o, err_o, int_o status
//   in_rd_addr_o, in_rd_data_i   input buffer read port (1-cycle latency)
//   core_next_o, core_x_o        frame-start pulse and sample stream to core
//   core_next_out_i, core_y_i    output-frame marker and result stream
//   out_we_o, out_addr_o, out_data_o  output buffer write port
//   cont_i                       continuous mode (only with the macro below)
//
// Optional feature macro: IDFT_FRAME_SEQ_CONT_EN
//   When defined, cont_i=1 in DONE re-kicks the core immediately.

module idft_frame_seq #(
  parameter int N       = 32,
  parameter int AW      = 5,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          start_i,
  input  logic          clr_i,
`ifdef IDFT_FRAME_SEQ_CONT_EN
  input  logic          cont_i,
`endif
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          int_o,
  output logic [AW-1:0] in_rd_addr_o,
  input  logic [DW-1:0] in_rd_data_i,
  output logic          core_next_o,
  output logic [DW-1:0] core_x_o,
  input  logic          core_next_out_i,
  input  logic [DW-1:0] core_y_i,
  output logic          out_we_o,
  output logic [AW-1:0] out_addr_o,
  output logic [DW-1:0] out_data_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_FEED,
    S_WAIT,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;       // sample index in FEED, result index in DRAIN
  logic [TW-1:0] tcnt;      // cycles since KICK (0 during KICK)
  logic [TW-1:0] tcnt_inc;
  logic          err_q;
  logic          int_q;
  logic          again;

  assign tcnt_inc = (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + TW'(1);

`ifdef IDFT_FRAME_SEQ_CONT_EN
  assign again = cont_i;
`else
  assign again = 1'b0;
`endif

  // Sticky flags are set on entry to DONE/ERR so they rise together with
  // done_o / the ERR cycle; a set written later in this block overrides clr_i.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= S_IDLE;
      cnt   <= '0;
      tcnt  <= '0;
      err_q <= 1'b0;
      int_q <= 1'b0;
    end else begin
      if (clr_i) begin
        err_q <= 1'b0;
        int_q <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state <= S_KICK;
            cnt   <= '0;
            tcnt  <= '0;
          end
        end
        S_KICK: begin
          tcnt <= tcnt_inc;
          if (core_next_out_i) begin
            state <= S_ERR;
            err_q <= 1'b1;
            int_q <= 1'b1;
          end else begin
            state <= S_FEED;
          end
        end
        S_FEED: begin
          tcnt <= tcnt_inc;
          cnt  <= cnt + AW'(1);   // wraps to 0 after the last sample
          if (core_next_out_i) begin
            state <= S_ERR;
            err_q <= 1'b1;
            int_q <= 1'b1;
          end else if (cnt == AW'(N - 1)) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          tcnt <= tcnt_inc;
          // The core marker takes priority over a timeout in the same cycle.
          if (core_next_out_i) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else if (tcnt_inc == TW'(TIMEOUT)) begin
            state <= S_ERR;
            err_q <= 1'b1;
            int_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(N - 1)) begin
            state <= S_DONE;
            int_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (again) begin
            state <= S_KICK;
            cnt   <= '0;
            tcnt  <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ERR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only the state/counter flops, so reset forces them to 0.
  assign busy_o       = (state != S_IDLE);
  assign done_o       = (state == S_DONE);
  assign err_o        = err_q;
  assign int_o        = int_q;
  assign core_next_o  = (state == S_KICK);
  // Read one sample ahead to cover the buffer's 1-cycle read latency.
  assign in_rd_addr_o = (state == S_FEED) ? cnt + AW'(1) : '0;
  assign core_x_o     = (state == S_FEED) ? in_rd_data_i : '0;
  assign out_we_o     = (state == S_DRAIN);
  assign out_addr_o   = (state == S_DRAIN) ? cnt : '0;
  assign out_data_o   = (state == S_DRAIN) ? core_y_i : '0;

endmodule

// File: tb/tb_idft_frame_seq.sv
// tb/tb_idft_frame_seq.sv - self-checking bench for idft_frame_seq
module tb_idft_frame_seq;
  localparam int N = 32, AW = 5, DW = 64, TIMEOUT = 1024, TW = 11;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0;
  logic [AW-1:0] in_rd_addr, out_addr;
  logic [DW-1:0] in_rd_data = '0, core_x, core_y = '0, out_data;
  logic core_next, core_next_out = 1'b0;
  logic busy, done, err, irq, out_we;
`ifdef IDFT_FRAME_SEQ_CONT_EN
  logic cont = 1'b0;
`endif

  idft_frame_seq #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .clr_i(clr),
`ifdef IDFT_FRAME_SEQ_CONT_EN
    .cont_i(cont),
`endif
    .busy_o(busy), .done_o(done), .err_o(err), .int_o(irq),
    .in_rd_addr_o(in_rd_addr), .in_rd_data_i(in_rd_data),
    .core_next_o(core_next), .core_x_o(core_x),
    .core_next_out_i(core_next_out), .core_y_i(core_y),
    .out_we_o(out_we), .out_addr_o(out_addr), .out_data_o(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] cap [N];
  int lat = 0, early = -1, kick_c = -100000;
  int kc, yj;

  // Environment: input RAM with 1-cycle read latency and an echo core that
  // raises next_out lat cycles after its kick (or at FEED sample 'early').
  assign kc = core_next ? cyc : kick_c;
  assign yj = cyc + 1 - (kc + lat + 1);
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    in_rd_data <= mem[in_rd_addr];
    kick_c     <= kc;
    if (cyc >= kc + 1 && cyc <= kc + N) cap[cyc-kc-1] <= core_x;
    core_next_out <= (lat > 0 && cyc + 1 == kc + lat) ||
                     (early >= 0 && cyc + 1 == kc + 1 + early);
    if (lat > 0 && yj >= 0 && yj < N) core_y <= cap[yj];
    else core_y <= {$urandom, $urandom};
  end

  // Event logs sampled mid-cycle.
  int kicks[$], dones[$], errs[$], wr_cyc[$], xo[$];
  logic [DW-1:0] xq[$], wr_data[$];
  logic [AW-1:0] wr_addr[$];
  logic err_d = 1'b0;
  always @(negedge clk) begin
    err_d <= err;
    if (core_next) kicks.push_back(cyc);
    if (done) dones.push_back(cyc);
    if (err && !err_d) errs.push_back(cyc);
    if (out_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(out_addr);
      wr_data.push_back(out_data);
    end
    if (cyc >= kick_c + 1 && cyc <= kick_c + N) xq.push_back(core_x);
    else if (core_x != '0) xo.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    kicks.delete(); dones.delete(); errs.delete(); wr_cyc.delete();
    xo.delete(); xq.delete(); wr_data.delete(); wr_addr.delete();
  endtask

  task automatic start_frame(output int s);
    @(negedge clk);
    clear_logs();
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) mem[k] = {$urandom, $urandom};
  endtask

  // A good frame kicked at s+1 with marker at kick+l: samples 0..N-1 streamed,
  // results j=0..N-1 written from kick+l+1, done at start + 1+1+N+W+N+1 - 1.
  task automatic check_frame(input string tag, input int s, input int l);
    int bad;
    repeat (3) @(negedge clk);
    chk({tag, "_kicks"}, kicks.size(), 1);
    if (kicks.size() > 0) chk({tag, "_kick_cyc"}, kicks[0], s + 1);
    chk({tag, "_x_cnt"}, xq.size(), N);
    bad = 0;
    for (int k = 0; k < xq.size() && k < N; k++) if (xq[k] !== mem[k]) bad++;
    chk({tag, "_x_bad"}, bad, 0);
    chk({tag, "_x_outside"}, xo.size(), 0);
    chk({tag, "_wr_cnt"}, wr_addr.size(), N);
    bad = 0;
    for (int j = 0; j < wr_addr.size() && j < N; j++)
      if (wr_addr[j] !== AW'(j) || wr_data[j] !== mem[j]) bad++;
    chk({tag, "_wr_bad"}, bad, 0);
    if (wr_cyc.size() > 0) chk({tag, "_wr_first"}, wr_cyc[0], s + 1 + l + 1);
    chk({tag, "_dones"}, dones.size(), 1);
    if (dones.size() > 0) chk({tag, "_done_cyc"}, dones[0], s + (1 + 1 + N + (l - N) + N + 1) - 1);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d;
    for (int k = 0; k < N; k++) mem[k] = DW'(k);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_int", irq, 0);
    chk("rst_next", core_next, 0);
    chk("rst_we", out_we, 0);
    chk("rst_rdaddr", in_rd_addr, 0);
    chk("rst_x", core_x, 0);
    chk("rst_oaddr", out_addr, 0);
    chk("rst_odata", out_data, 0);
    rst_n = 1'b1;

    // Nominal frame: ramp data, 40-cycle core.
    lat = 40;
    start_frame(s);
    wait_idle("nom", 300);
    check_frame("nom", s, lat);
    chk("nom_int", irq, 1);

    // Minimum WAIT (one cycle) with random data.
    clr_pulse();
    chk("clr_int", irq, 0);
    fill_random();
    lat = N + 1;
    start_frame(s);
    wait_idle("minw", 300);
    check_frame("minw", s, lat);

    // Timeout: core never answers.
    clr_pulse();
    lat = 0;
    start_frame(s);
    wait_idle("tmo", 1300);
    repeat (2) @(negedge clk);
    chk("tmo_errs", errs.size(), 1);
    if (errs.size() > 0) chk("tmo_err_cyc", errs[0], s + 1 + TIMEOUT);
    chk("tmo_err", err, 1);
    chk("tmo_int", irq, 1);
    chk("tmo_wr", wr_addr.size(), 0);
    chk("tmo_done", dones.size(), 0);

    // Marker on the very cycle the timeout would fire: marker wins.
    clr_pulse();
    fill_random();
    lat = TIMEOUT - 1;
    start_frame(s);
    wait_idle("tie", 1300);
    check_frame("tie", s, lat);

    // Start while busy is ignored.
    clr_pulse();
    fill_random();
    lat = $urandom_range(N + 2, N + 100);
    start_frame(s);
    wait_cyc(s + 1 + 1 + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy", 400);
    check_frame("busy", s, lat);

    // Early marker at FEED sample 5.
    clr_pulse();
    lat = 0;
    early = 5;
    start_frame(s);
    wait_idle("early", 100);
    early = -1;
    repeat (2) @(negedge clk);
    chk("early_errs", errs.size(), 1);
    if (errs.size() > 0) chk("early_err_cyc", errs[0], s + 1 + 7);
    chk("early_err", err, 1);
    chk("early_wr", wr_addr.size(), 0);
    chk("early_done", dones.size(), 0);

    // Reset at DRAIN j=7.
    clr_pulse();
    fill_random();
    lat = $urandom_range(N + 2, N + 60);
    start_frame(s);
    wait_cyc(s + 1 + lat + 1 + 7);
    chk("mrst_pre_addr", out_addr, 7);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_we", out_we, 0);
    chk("mrst_oaddr", out_addr, 0);
    chk("mrst_odata", out_data, 0);
    chk("mrst_done", done, 0);
    chk("mrst_int", irq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_dones", dones.size(), 0);
    chk("mrst_int_after", irq, 0);
    lat = $urandom_range(N + 2, N + 60);
    start_frame(s);
    wait_idle("fresh", 400);
    check_frame("fresh", s, lat);

    // Clear racing the int set edge (last DRAIN cycle): set wins.
    clr_pulse();
    fill_random();
    lat = $urandom_range(N + 2, N + 80);
    start_frame(s);
    d = s + lat + N + 2;
    wait_cyc(d - 1);
    clr = 1'b1;
    @(negedge clk);
    chk("race_done", done, 1);
    chk("race_int_set", irq, 1);
    @(negedge clk);
    clr = 1'b0;
    chk("race_int_clr", irq, 0);
    wait_idle("race", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
